// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// byte width and default timing constants.
package uart_pkg;

    localparam int UART_DATA_W             = 8;
    localparam int UART_GAP_CYCLES_DEF     = 2;
    localparam int UART_TIMEOUT_CYCLES_DEF = 20000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: scans the valid vector starting one
// position after last_grant_i and returns the first set index.
module uart_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic                       any_o,
    output logic [$clog2(NUM_REQ)-1:0] winner_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               idx;
    logic [IDX_W-1:0] sel;

    // Walk candidates from farthest to nearest so the nearest valid one wins.
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        idx      = 0;
        sel      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(last_grant_i) + 1 + k) % NUM_REQ;
            sel = IDX_W'(idx);
            if (valid_i[sel]) begin
                any_o    = 1'b1;
                winner_o = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional tx_done watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = UART_GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_done,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    uart_arb_state_t        state_q, state_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_winner;
    logic             grant_now;
    logic             gap_last;
    logic             wd_expired;

    uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid_i      (req_valid),
        .last_grant_i (last_q),
        .any_o        (pick_any),
        .winner_o     (pick_winner)
    );

    // A grant is only issued out of reset, so req_ready stays low while rst is asserted.
    assign grant_now = (state_q == ST_IDLE) && pick_any && rst;
    assign gap_last  = (int'(gap_cnt_q) == GAP_CYCLES - 1);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q;

    // The watchdog fires on the TIMEOUT_CYCLES-th WAIT_DONE cycle; tx_done on that cycle wins.
    assign wd_expired = (state_q == ST_WAIT_DONE) && !tx_done &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign wd_cnt_d   = (state_q == ST_WAIT_DONE) ? wd_cnt_q + WD_W'(1) : '0;

    // Watchdog counter and one-cycle abort pulse, visible as the FSM lands in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= wd_expired;
        end
    end

    assign err_timeout = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign wd_expired  = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (pick_any) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done)         state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                else if (wd_expired) state_d = ST_IDLE;
            end
            ST_GAP:       if (gap_last) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's byte and index on grant; remember who finished last.
    always_comb begin
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        gap_cnt_d = '0;
        if (grant_now) begin
            grant_d = pick_winner;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick_winner == IDX_W'(i)) tx_data_d = req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
        if ((state_q == ST_WAIT_DONE) && (tx_done || wd_expired)) last_d = grant_q;
        if (state_q == ST_GAP) gap_cnt_d = gap_cnt_q + GAP_W'(1);
    end

    // Datapath registers; last grant resets to NUM_REQ-1 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_data_q <= '0;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            gap_cnt_q <= '0;
        end else begin
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Output decode from state and the current grant decision.
    always_comb begin
        req_ready = '0;
        if (grant_now) req_ready[pick_winner] = 1'b1;
        tx_start  = (state_q == ST_ISSUE);
        busy      = (state_q != ST_IDLE);
    end

    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;

endmodule
